// File: rtl/input_selecter_top.sv
// input_selecter_top: operand selector for a two-pass 4x4 2D FFT.
//   Pass 1 (rows) loads the external matrix ext_in_*. Pass 2 (columns) loads
//   the pass-1 results rt_in_* (transposed when TRANSPOSE=1), saturated from
//   OUT_W down to IN_W bits. A watchdog aborts a pass after WAIT_MAX cycles
//   without an accepted fft_done.
// Ports:
//   clk, reset (sync, active high), start    - control inputs
//   ext_in_R_C_r/_i  [IN_W]                  - external samples, R,C in 1..4
//   rt_in_R_C_r/_i   [OUT_W]                 - pass-1 results
//   fft_done                                 - FFT core result-valid pulse
//   sel_out_R_C_r/_i [IN_W]                  - registered operand matrix
//   fft_start, pass, busy, done, err         - registered status outputs
// OUT_W must be >= IN_W.

module input_selecter_lane #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 20
) (
  input  logic [OUT_W-1:0] rt_i,
  output logic [IN_W-1:0]  sat_o
);
  // Signed IN_W range bounds expressed at OUT_W width.
  localparam logic signed [OUT_W-1:0] SMAX = {{(OUT_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SMIN = ~SMAX;

  always_comb begin
    sat_o = rt_i[IN_W-1:0];
    if ($signed(rt_i) > SMAX)      sat_o = SMAX[IN_W-1:0];
    else if ($signed(rt_i) < SMIN) sat_o = SMIN[IN_W-1:0];
  end
endmodule

module input_selecter_top #(
  parameter int WAIT_MAX  = 255,
  parameter bit TRANSPOSE = 1'b1,
  parameter int IN_W      = 16,
  parameter int OUT_W     = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic signed [IN_W-1:0]  ext_in_1_1_r, ext_in_1_2_r, ext_in_1_3_r, ext_in_1_4_r,
  input  logic signed [IN_W-1:0]  ext_in_2_1_r, ext_in_2_2_r, ext_in_2_3_r, ext_in_2_4_r,
  input  logic signed [IN_W-1:0]  ext_in_3_1_r, ext_in_3_2_r, ext_in_3_3_r, ext_in_3_4_r,
  input  logic signed [IN_W-1:0]  ext_in_4_1_r, ext_in_4_2_r, ext_in_4_3_r, ext_in_4_4_r,
  input  logic signed [IN_W-1:0]  ext_in_1_1_i, ext_in_1_2_i, ext_in_1_3_i, ext_in_1_4_i,
  input  logic signed [IN_W-1:0]  ext_in_2_1_i, ext_in_2_2_i, ext_in_2_3_i, ext_in_2_4_i,
  input  logic signed [IN_W-1:0]  ext_in_3_1_i, ext_in_3_2_i, ext_in_3_3_i, ext_in_3_4_i,
  input  logic signed [IN_W-1:0]  ext_in_4_1_i, ext_in_4_2_i, ext_in_4_3_i, ext_in_4_4_i,
  input  logic signed [OUT_W-1:0] rt_in_1_1_r, rt_in_1_2_r, rt_in_1_3_r, rt_in_1_4_r,
  input  logic signed [OUT_W-1:0] rt_in_2_1_r, rt_in_2_2_r, rt_in_2_3_r, rt_in_2_4_r,
  input  logic signed [OUT_W-1:0] rt_in_3_1_r, rt_in_3_2_r, rt_in_3_3_r, rt_in_3_4_r,
  input  logic signed [OUT_W-1:0] rt_in_4_1_r, rt_in_4_2_r, rt_in_4_3_r, rt_in_4_4_r,
  input  logic signed [OUT_W-1:0] rt_in_1_1_i, rt_in_1_2_i, rt_in_1_3_i, rt_in_1_4_i,
  input  logic signed [OUT_W-1:0] rt_in_2_1_i, rt_in_2_2_i, rt_in_2_3_i, rt_in_2_4_i,
  input  logic signed [OUT_W-1:0] rt_in_3_1_i, rt_in_3_2_i, rt_in_3_3_i, rt_in_3_4_i,
  input  logic signed [OUT_W-1:0] rt_in_4_1_i, rt_in_4_2_i, rt_in_4_3_i, rt_in_4_4_i,
  input  logic fft_done,
  output logic signed [IN_W-1:0]  sel_out_1_1_r, sel_out_1_2_r, sel_out_1_3_r, sel_out_1_4_r,
  output logic signed [IN_W-1:0]  sel_out_2_1_r, sel_out_2_2_r, sel_out_2_3_r, sel_out_2_4_r,
  output logic signed [IN_W-1:0]  sel_out_3_1_r, sel_out_3_2_r, sel_out_3_3_r, sel_out_3_4_r,
  output logic signed [IN_W-1:0]  sel_out_4_1_r, sel_out_4_2_r, sel_out_4_3_r, sel_out_4_4_r,
  output logic signed [IN_W-1:0]  sel_out_1_1_i, sel_out_1_2_i, sel_out_1_3_i, sel_out_1_4_i,
  output logic signed [IN_W-1:0]  sel_out_2_1_i, sel_out_2_2_i, sel_out_2_3_i, sel_out_2_4_i,
  output logic signed [IN_W-1:0]  sel_out_3_1_i, sel_out_3_2_i, sel_out_3_3_i, sel_out_3_4_i,
  output logic signed [IN_W-1:0]  sel_out_4_1_i, sel_out_4_2_i, sel_out_4_3_i, sel_out_4_4_i,
  output logic fft_start,
  output logic pass,
  output logic busy,
  output logic done,
  output logic err
);
  localparam int TW = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {IDLE, RUN1, RUN2, DONE} state_e;

  // Element k of each packed matrix is (R-1)*4 + (C-1).
  logic [15:0][IN_W-1:0]  ext_r, ext_i, load_r_d, load_i_d, sel_r_q, sel_i_q;
  logic [15:0][OUT_W-1:0] rt_r, rt_i;

  assign ext_r = {ext_in_4_4_r, ext_in_4_3_r, ext_in_4_2_r, ext_in_4_1_r, ext_in_3_4_r, ext_in_3_3_r,
                  ext_in_3_2_r, ext_in_3_1_r, ext_in_2_4_r, ext_in_2_3_r, ext_in_2_2_r, ext_in_2_1_r,
                  ext_in_1_4_r, ext_in_1_3_r, ext_in_1_2_r, ext_in_1_1_r};
  assign ext_i = {ext_in_4_4_i, ext_in_4_3_i, ext_in_4_2_i, ext_in_4_1_i, ext_in_3_4_i, ext_in_3_3_i,
                  ext_in_3_2_i, ext_in_3_1_i, ext_in_2_4_i, ext_in_2_3_i, ext_in_2_2_i, ext_in_2_1_i,
                  ext_in_1_4_i, ext_in_1_3_i, ext_in_1_2_i, ext_in_1_1_i};
  assign rt_r  = {rt_in_4_4_r, rt_in_4_3_r, rt_in_4_2_r, rt_in_4_1_r, rt_in_3_4_r, rt_in_3_3_r,
                  rt_in_3_2_r, rt_in_3_1_r, rt_in_2_4_r, rt_in_2_3_r, rt_in_2_2_r, rt_in_2_1_r,
                  rt_in_1_4_r, rt_in_1_3_r, rt_in_1_2_r, rt_in_1_1_r};
  assign rt_i  = {rt_in_4_4_i, rt_in_4_3_i, rt_in_4_2_i, rt_in_4_1_i, rt_in_3_4_i, rt_in_3_3_i,
                  rt_in_3_2_i, rt_in_3_1_i, rt_in_2_4_i, rt_in_2_3_i, rt_in_2_2_i, rt_in_2_1_i,
                  rt_in_1_4_i, rt_in_1_3_i, rt_in_1_2_i, rt_in_1_1_i};
  assign {sel_out_4_4_r, sel_out_4_3_r, sel_out_4_2_r, sel_out_4_1_r, sel_out_3_4_r, sel_out_3_3_r,
          sel_out_3_2_r, sel_out_3_1_r, sel_out_2_4_r, sel_out_2_3_r, sel_out_2_2_r, sel_out_2_1_r,
          sel_out_1_4_r, sel_out_1_3_r, sel_out_1_2_r, sel_out_1_1_r} = sel_r_q;
  assign {sel_out_4_4_i, sel_out_4_3_i, sel_out_4_2_i, sel_out_4_1_i, sel_out_3_4_i, sel_out_3_3_i,
          sel_out_3_2_i, sel_out_3_1_i, sel_out_2_4_i, sel_out_2_3_i, sel_out_2_2_i, sel_out_2_1_i,
          sel_out_1_4_i, sel_out_1_3_i, sel_out_1_2_i, sel_out_1_1_i} = sel_i_q;

  // Pass-2 load values: destination (r,c) takes source (c,r) when transposing.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      localparam int DST = r*4 + c;
      localparam int SRC = TRANSPOSE ? (c*4 + r) : DST;
      input_selecter_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane_r (
        .rt_i(rt_r[SRC]), .sat_o(load_r_d[DST]));
      input_selecter_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane_i (
        .rt_i(rt_i[SRC]), .sat_o(load_i_d[DST]));
    end
  end

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic          fft_start_q, pass_q, busy_q, done_q, err_q;

  assign fft_start = fft_start_q;
  assign pass      = pass_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  // timer_q counts cycles since fft_start; a done is only accepted once it is
  // non-zero, and the abort fires on the edge where it would reach WAIT_MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      sel_r_q     <= '0;
      sel_i_q     <= '0;
      fft_start_q <= 1'b0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      fft_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          sel_r_q     <= ext_r;
          sel_i_q     <= ext_i;
          pass_q      <= 1'b0;
          fft_start_q <= 1'b1;
          busy_q      <= 1'b1;
          timer_q     <= '0;
          state_q     <= RUN1;
        end
        RUN1, RUN2: begin
          if (fft_done && timer_q != '0) begin
            timer_q <= '0;
            if (state_q == RUN1) begin
              sel_r_q     <= load_r_d;
              sel_i_q     <= load_i_d;
              pass_q      <= 1'b1;
              fft_start_q <= 1'b1;
              state_q     <= RUN2;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else if (timer_q == TW'(WAIT_MAX - 1)) begin
            err_q   <= 1'b1;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            timer_q <= '0;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          pass_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_input_selecter_top.sv
module tb_input_selecter_top;
  localparam int IN_W = 16, OUT_W = 20, WAIT_MAX = 8;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, fft_done = 1'b0;
  logic signed [IN_W-1:0]  ext_r [16], ext_i [16], so_r [16], so_i [16];
  logic signed [OUT_W-1:0] rt_r [16], rt_i [16];
  logic fft_start, pass, busy, done, err;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  input_selecter_top #(.WAIT_MAX(WAIT_MAX), .TRANSPOSE(1'b1), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .fft_done(fft_done),
    .ext_in_1_1_r(ext_r[0]),  .ext_in_1_2_r(ext_r[1]),  .ext_in_1_3_r(ext_r[2]),  .ext_in_1_4_r(ext_r[3]),
    .ext_in_2_1_r(ext_r[4]),  .ext_in_2_2_r(ext_r[5]),  .ext_in_2_3_r(ext_r[6]),  .ext_in_2_4_r(ext_r[7]),
    .ext_in_3_1_r(ext_r[8]),  .ext_in_3_2_r(ext_r[9]),  .ext_in_3_3_r(ext_r[10]), .ext_in_3_4_r(ext_r[11]),
    .ext_in_4_1_r(ext_r[12]), .ext_in_4_2_r(ext_r[13]), .ext_in_4_3_r(ext_r[14]), .ext_in_4_4_r(ext_r[15]),
    .ext_in_1_1_i(ext_i[0]),  .ext_in_1_2_i(ext_i[1]),  .ext_in_1_3_i(ext_i[2]),  .ext_in_1_4_i(ext_i[3]),
    .ext_in_2_1_i(ext_i[4]),  .ext_in_2_2_i(ext_i[5]),  .ext_in_2_3_i(ext_i[6]),  .ext_in_2_4_i(ext_i[7]),
    .ext_in_3_1_i(ext_i[8]),  .ext_in_3_2_i(ext_i[9]),  .ext_in_3_3_i(ext_i[10]), .ext_in_3_4_i(ext_i[11]),
    .ext_in_4_1_i(ext_i[12]), .ext_in_4_2_i(ext_i[13]), .ext_in_4_3_i(ext_i[14]), .ext_in_4_4_i(ext_i[15]),
    .rt_in_1_1_r(rt_r[0]),  .rt_in_1_2_r(rt_r[1]),  .rt_in_1_3_r(rt_r[2]),  .rt_in_1_4_r(rt_r[3]),
    .rt_in_2_1_r(rt_r[4]),  .rt_in_2_2_r(rt_r[5]),  .rt_in_2_3_r(rt_r[6]),  .rt_in_2_4_r(rt_r[7]),
    .rt_in_3_1_r(rt_r[8]),  .rt_in_3_2_r(rt_r[9]),  .rt_in_3_3_r(rt_r[10]), .rt_in_3_4_r(rt_r[11]),
    .rt_in_4_1_r(rt_r[12]), .rt_in_4_2_r(rt_r[13]), .rt_in_4_3_r(rt_r[14]), .rt_in_4_4_r(rt_r[15]),
    .rt_in_1_1_i(rt_i[0]),  .rt_in_1_2_i(rt_i[1]),  .rt_in_1_3_i(rt_i[2]),  .rt_in_1_4_i(rt_i[3]),
    .rt_in_2_1_i(rt_i[4]),  .rt_in_2_2_i(rt_i[5]),  .rt_in_2_3_i(rt_i[6]),  .rt_in_2_4_i(rt_i[7]),
    .rt_in_3_1_i(rt_i[8]),  .rt_in_3_2_i(rt_i[9]),  .rt_in_3_3_i(rt_i[10]), .rt_in_3_4_i(rt_i[11]),
    .rt_in_4_1_i(rt_i[12]), .rt_in_4_2_i(rt_i[13]), .rt_in_4_3_i(rt_i[14]), .rt_in_4_4_i(rt_i[15]),
    .sel_out_1_1_r(so_r[0]),  .sel_out_1_2_r(so_r[1]),  .sel_out_1_3_r(so_r[2]),  .sel_out_1_4_r(so_r[3]),
    .sel_out_2_1_r(so_r[4]),  .sel_out_2_2_r(so_r[5]),  .sel_out_2_3_r(so_r[6]),  .sel_out_2_4_r(so_r[7]),
    .sel_out_3_1_r(so_r[8]),  .sel_out_3_2_r(so_r[9]),  .sel_out_3_3_r(so_r[10]), .sel_out_3_4_r(so_r[11]),
    .sel_out_4_1_r(so_r[12]), .sel_out_4_2_r(so_r[13]), .sel_out_4_3_r(so_r[14]), .sel_out_4_4_r(so_r[15]),
    .sel_out_1_1_i(so_i[0]),  .sel_out_1_2_i(so_i[1]),  .sel_out_1_3_i(so_i[2]),  .sel_out_1_4_i(so_i[3]),
    .sel_out_2_1_i(so_i[4]),  .sel_out_2_2_i(so_i[5]),  .sel_out_2_3_i(so_i[6]),  .sel_out_2_4_i(so_i[7]),
    .sel_out_3_1_i(so_i[8]),  .sel_out_3_2_i(so_i[9]),  .sel_out_3_3_i(so_i[10]), .sel_out_3_4_i(so_i[11]),
    .sel_out_4_1_i(so_i[12]), .sel_out_4_2_i(so_i[13]), .sel_out_4_3_i(so_i[14]), .sel_out_4_4_i(so_i[15]),
    .fft_start(fft_start), .pass(pass), .busy(busy), .done(done), .err(err)
  );

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 first pass, 2 second pass, 3 completion cycle.
  // age: cycles elapsed since the most recent fft_start cycle.
  int m_r [16], m_i [16];
  bit m_fs, m_pass, m_busy, m_done, m_err, m_valid = 1'b0;
  int phase = 0, age = 0;

  function automatic int clampv(input int v);
    int lim = 1 << (IN_W - 1);
    if (v > lim - 1) return lim - 1;
    if (v < -lim)    return -lim;
    return v;
  endfunction

  task automatic model_step();
    if (reset) begin
      for (int k = 0; k < 16; k++) begin m_r[k] = 0; m_i[k] = 0; end
      {m_fs, m_pass, m_busy, m_done, m_err} = '0;
      phase = 0; age = 0; m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    m_fs = 0; m_done = 0; m_err = 0;
    if (phase == 0) begin
      if (start) begin
        for (int k = 0; k < 16; k++) begin m_r[k] = int'(ext_r[k]); m_i[k] = int'(ext_i[k]); end
        m_pass = 0; m_fs = 1; m_busy = 1; phase = 1; age = 0;
      end
    end else if (phase == 3) begin
      m_pass = 0; m_busy = 0; phase = 0;
    end else if (fft_done && age > 0) begin
      if (phase == 1) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            m_r[r*4+c] = clampv(int'(rt_r[c*4+r]));
            m_i[r*4+c] = clampv(int'(rt_i[c*4+r]));
          end
        m_pass = 1; m_fs = 1; phase = 2; age = 0;
      end else begin
        m_done = 1; phase = 3;
      end
    end else if (age + 1 >= WAIT_MAX) begin
      m_err = 1; m_pass = 0; m_busy = 0; phase = 0;
    end else begin
      age++;
    end
  endtask

  // Advance one clock: model and DUT see the same inputs at the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      int bad;
      chk("ctrl{fs,pass,busy,done,err}", int'({fft_start, pass, busy, done, err}),
          int'({m_fs, m_pass, m_busy, m_done, m_err}));
      bad = -1;
      for (int k = 0; k < 16; k++)
        if (bad < 0 && (int'(so_r[k]) != m_r[k] || int'(so_i[k]) != m_i[k])) bad = k;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL sel_out[%0d]: got r=%0d i=%0d expected r=%0d i=%0d (t=%0t)",
                 bad, so_r[bad], so_i[bad], m_r[bad], m_i[bad], $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int nz;
    logic signed [IN_W-1:0] t;
    for (int k = 0; k < 16; k++) begin ext_r[k] = '0; ext_i[k] = '0; rt_r[k] = '0; rt_i[k] = '0; end
    repeat (3) tick();
    chk("reset_ctrl", int'({fft_start, pass, busy, done, err}), 0);
    reset = 1'b0;

    // Directed pass sequence with ramp data; cycle numbers relative to start.
    for (int k = 0; k < 16; k++) begin
      ext_r[k] = IN_W'(10*(k/4 + 1) + (k%4 + 1));
      rt_r[k]  = OUT_W'(10*(k/4 + 1) + (k%4 + 1));
    end
    start = 1'b1; tick();                        // cycle 1
    start = 1'b0; fft_done = 1'b1;               // done coincident with fft_start
    chk("c1_fft_start", int'(fft_start), 1);
    chk("c1_pass", int'(pass), 0);
    chk("c1_busy", int'(busy), 1);
    chk("c1_sel23r", int'(so_r[6]), 23);
    chk("c1_model_sel23r", m_r[6], 23);
    tick();                                      // cycle 2
    fft_done = 1'b0; start = 1'b1;               // start inside RUN1
    chk("c2_done_ignored_pass", int'(pass), 0);
    chk("c2_done_ignored_fs", int'(fft_start), 0);
    tick();                                      // cycle 3
    start = 1'b0;
    chk("c3_start_ignored_fs", int'(fft_start), 0);
    chk("c3_start_ignored_sel", int'(so_r[6]), 23);
    tick(); tick();                              // cycle 5
    fft_done = 1'b1; tick();                     // cycle 6
    fft_done = 1'b0;
    chk("c6_fft_start", int'(fft_start), 1);
    chk("c6_pass", int'(pass), 1);
    chk("c6_sel23r", int'(so_r[6]), 32);
    chk("c6_sel41r", int'(so_r[12]), 14);
    chk("c6_model_sel41r", m_r[12], 14);
    tick(); tick(); tick();                      // cycle 9
    fft_done = 1'b1; tick();                     // cycle 10
    fft_done = 1'b0;
    chk("c10_done", int'(done), 1);
    chk("c10_pass", int'(pass), 1);
    tick();                                      // cycle 11
    chk("c11_busy", int'(busy), 0);
    chk("c11_pass", int'(pass), 0);
    chk("c11_done", int'(done), 0);

    // Saturation on pass-2 load, then reset in the middle of RUN2.
    start = 1'b1; tick();
    start = 1'b0; tick();
    rt_r[0] = 20'sd40000; rt_i[1] = -20'sd40000; fft_done = 1'b1; tick();
    fft_done = 1'b0;
    chk("sat_sel11r", int'(so_r[0]), 32767);
    chk("sat_sel21i", int'(so_i[4]), -32768);
    chk("sat_model_sel21i", m_i[4], -32768);
    tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    nz = 0;
    for (int k = 0; k < 16; k++) if (so_r[k] != 0 || so_i[k] != 0) nz++;
    chk("rst_run2_ctrl", int'({fft_start, pass, busy, done, err}), 0);
    chk("rst_run2_sel_nonzero", nz, 0);
    tick();
    chk("rst_run2_no_done", int'(done | err), 0);

    // Watchdog: no fft_done at all.
    start = 1'b1; tick();                        // cycle 1
    start = 1'b0;
    chk("wd_fft_start", int'(fft_start), 1);
    for (int n = 2; n <= 11; n++) begin
      tick();
      chk($sformatf("wd_err_c%0d", n), int'(err), (n == 1 + WAIT_MAX) ? 1 : 0);
      chk($sformatf("wd_done_c%0d", n), int'(done), 0);
    end
    chk("wd_busy_after", int'(busy), 0);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 16; k++) begin
        ext_r[k] = IN_W'($urandom); ext_i[k] = IN_W'($urandom);
        if ($urandom_range(3) == 0) begin
          rt_r[k] = OUT_W'($urandom); rt_i[k] = OUT_W'($urandom);
        end else begin
          t = IN_W'($urandom); rt_r[k] = t;
          t = IN_W'($urandom); rt_i[k] = t;
        end
      end
      start    = ($urandom_range(3) == 0);
      fft_done = ($urandom_range(5) == 0);
      reset    = ($urandom_range(99) == 0);
      tick();
    end
    start = 1'b0; fft_done = 1'b0; reset = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
